// File: rtl/fp16_conv_arbiter_if.sv
// Request/response and converter-side signal bundle for fp16_conv_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fp16_conv_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [15:0]         rsp_data;
    logic                rsp_error;
    logic                rsp_timeout;
    logic                busy;
    logic [15:0]         conv_data_in;
    logic                conv_ri;
    logic                conv_reset;
    logic [15:0]         conv_data_out;
    logic                conv_ro;
    logic                conv_error;

    modport slave (
        input  req_valid, req_data, conv_data_out, conv_ro, conv_error,
        output req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout, busy,
               conv_data_in, conv_ri, conv_reset
    );

    modport master (
        output req_valid, req_data, conv_data_out, conv_ro, conv_error,
        input  req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout, busy,
               conv_data_in, conv_ri, conv_reset
    );
endinterface

// File: rtl/fp16_conv_arbiter.sv
// Round-robin sharing of one int16-to-FP16 converter between N_REQ requesters,
// with a completion timeout that recovers the converter through a reset pulse.
module fp16_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    fp16_conv_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_d;
    logic [1:0]       fcnt, fcnt_d;
    logic             issue_ph, issue_ph_d;
    logic [7:0]       tcnt, tcnt_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [IW-1:0]    sel, sel_d;
    logic             to_flag, to_flag_d;

    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             busy_q, busy_d;
    logic [15:0]      conv_din_q, conv_din_d;
    logic             conv_ri_q, conv_ri_d;
    logic             conv_reset_q, conv_reset_d;

    logic             grant_hit;
    logic [IW-1:0]    grant_idx;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= unsigned'(N_REQ)) s = s - unsigned'(N_REQ);
        return IW'(s);
    endfunction

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < unsigned'(N_REQ); i++) begin
            if (!grant_hit && bus.req_valid[rr_index(ptr, i)]) begin
                grant_hit = 1'b1;
                grant_idx = rr_index(ptr, i);
            end
        end
    end

    always_comb begin
        state_d       = state;
        fcnt_d        = fcnt;
        issue_ph_d    = issue_ph;
        tcnt_d        = tcnt;
        ptr_d         = ptr;
        sel_d         = sel;
        to_flag_d     = to_flag;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        conv_din_d    = conv_din_q;
        conv_ri_d     = 1'b0;
        conv_reset_d  = 1'b0;

        case (state)
            FLUSH: begin
                conv_reset_d = (fcnt == 2'd0);
                if (fcnt == 2'd2) begin
                    fcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt + 2'd1;
                end
            end
            IDLE: begin
                if (grant_hit) begin
                    req_ready_d = N_REQ'(1) << grant_idx;
                    conv_din_d  = bus.req_data[16*grant_idx +: 16];
                    sel_d       = grant_idx;
                    ptr_d       = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    tcnt_d      = '0;
                    issue_ph_d  = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Registered strobe: the second ri cycle is already seen as WAIT,
                // so a completion during it is accepted there.
                conv_ri_d  = 1'b1;
                tcnt_d     = tcnt + 8'd1;
                issue_ph_d = 1'b1;
                if (issue_ph) state_d = WAIT;
            end
            WAIT: begin
                tcnt_d = tcnt + 8'd1;
                if (bus.conv_error || bus.conv_ro || tcnt == 8'(TIMEOUT)) begin
                    rsp_valid_d   = N_REQ'(1) << sel;
                    state_d       = DONE;
                    rsp_timeout_d = 1'b0;
                    to_flag_d     = 1'b0;
                    if (bus.conv_error) begin
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                    end else if (bus.conv_ro) begin
                        rsp_error_d = 1'b0;
                        rsp_data_d  = bus.conv_data_out;
                    end else begin
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_data_d    = '0;
                        to_flag_d     = 1'b1;
                    end
                end
            end
            DONE: begin
                fcnt_d  = '0;
                state_d = to_flag ? FLUSH : IDLE;
            end
            default: state_d = FLUSH;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FLUSH;
            fcnt          <= '0;
            issue_ph      <= 1'b0;
            tcnt          <= '0;
            ptr           <= '0;
            sel           <= '0;
            to_flag       <= 1'b0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            conv_din_q    <= '0;
            conv_ri_q     <= 1'b0;
            conv_reset_q  <= 1'b0;
        end else begin
            state         <= state_d;
            fcnt          <= fcnt_d;
            issue_ph      <= issue_ph_d;
            tcnt          <= tcnt_d;
            ptr           <= ptr_d;
            sel           <= sel_d;
            to_flag       <= to_flag_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            conv_din_q    <= conv_din_d;
            conv_ri_q     <= conv_ri_d;
            conv_reset_q  <= conv_reset_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.busy         = busy_q;
    assign bus.conv_data_in = conv_din_q;
    assign bus.conv_ri      = conv_ri_q;
    assign bus.conv_reset   = conv_reset_q;
endmodule

// File: doc/fp16_conv_arbiter.md
Name: fp16_conv_arbiter

Overview:
- Round-robin controller that shares one int16-to-FP16 converter between N_REQ requesters.
- Per requester: captures the operand, issues it to the converter with the conv_ri strobe, waits for conv_ro or conv_error, then returns the result on the shared response bus.
- Recovers a hung converter with a timeout and a converter reset pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 15, cycles allowed from first issue cycle to completion (4..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request, held high until accepted.
- req_data  in  16*N_REQ  operands; requester k uses bits [16k+15:16k].
- req_ready  out  N_REQ  one-hot, 1-cycle pulse: operand of requester k captured.
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse: response for requester k.
- rsp_data  out  16  FP16 result; 0 when rsp_error=1.
- rsp_error  out  1  conversion error or timeout; valid with rsp_valid.
- rsp_timeout  out  1  error was caused by timeout; valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- conv_data_in  out  16  operand to converter, held stable in ISSUE and WAIT.
- conv_ri  out  1  converter input strobe.
- conv_reset  out  1  converter synchronous reset.
- conv_data_out  in  16  converter result.
- conv_ro  in  1  converter done pulse.
- conv_error  in  1  converter overflow pulse (|operand| > 2048).

Behaviour:
- All outputs are registered.
- Async reset clears all outputs to 0, sets the RR pointer to 0, clears the timeout counter, and enters FLUSH.
- States: FLUSH, IDLE, ISSUE, WAIT, DONE.
- FLUSH (3 cycles):
  - Cycle 1: conv_reset=1.
  - Cycles 2-3: conv_reset=0, idle, so the converter reaches its input-wait state.
  - Then go to IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Capture that operand into conv_data_in, pulse req_ready[k], latch k, set ptr=(k+1) mod N_REQ, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: conv_ri=1 for exactly 2 consecutive cycles so that one of them meets the converter's input state; the timeout counter starts at 1 on the first ISSUE cycle; then go to WAIT. conv_ri=0 in every other state.
- WAIT: counter increments every cycle.
  - conv_error=1 → rsp_error=1, rsp_data=0.
  - Else conv_ro=1 → rsp_data=conv_data_out, rsp_error=0.
  - Else counter reaches TIMEOUT → rsp_error=1, rsp_timeout=1, rsp_data=0.
  - In all three cases go to DONE.
- DONE (1 cycle): rsp_valid[k]=1 with the rsp_* fields above. Next state is FLUSH after a timeout, IDLE otherwise.
- Completion arriving during the second ISSUE cycle is accepted exactly as in WAIT.
- conv_ro and conv_error in the same cycle: error wins.
- conv_ro or conv_error seen in FLUSH or IDLE is ignored.
- Latency, successful conversion: req_ready at cycle t → ISSUE t+1..t+2 → completion sampled at cycle c → rsp_valid at c+1.
- Only one operation is in flight; a new grant is made only from IDLE.
- req_valid dropping before grant withdraws the request with no side effects.
- rsp_data, rsp_error and rsp_timeout hold their values until the next DONE.
- Reset mid-operation: the operation is abandoned, no rsp_valid is produced, and FLUSH runs.

Test Plan:
- Requester 0, req_data=0x0005 → one req_ready[0] pulse, then rsp_valid[0], rsp_data=0x4500, rsp_error=0.
- Requester 2, 0xFFFF (−1) → rsp_valid[2], rsp_data=0xBC00; operand 0x0000 → rsp_data=0x0000.
- Requester 1, 0x1000 (4096) → converter pulses conv_error → rsp_valid[1], rsp_error=1, rsp_timeout=0, rsp_data=0.
- All 4 requesters valid continuously from reset → grant order 0,1,2,3,0,…; with only requesters 1 and 3 active → order 1,3,1,3.
- Converter model never responds → rsp_valid[k], rsp_error=1, rsp_timeout=1 at the cycle after the counter reaches 15, then a 1-cycle conv_reset pulse; a following request completes normally.
- Assert reset while in WAIT → no rsp_valid; all outputs 0 immediately; conv_reset pulses after release; a subsequent request from requester 0 is granted first.
